zeroriscy_instr_mem_responder: RTL and testbench

Responder (memory side) of the zero-riscy instruction fetch protocol: accepts `instr_req`/`instr_addr` from the core's prefetch buffer and returns grants, then in-order `rvalid`/`rdata` responses. Memory contents come from a word-addressed internal array preloaded through a backdoor load port. It sits between the core's instruction interface and the system boot/loader logic. It serves as the standard instruction memory for simulation and small FPGA builds, with configurable grant stall and response latency to stress the prefetch buffer.

---
 rtl/zeroriscy_instr_mem_responder_pkg.sv | 17 +
 rtl/zeroriscy_instr_mem_responder_if.sv | 12 +
 rtl/zeroriscy_instr_resp_pipe.sv | 48 ++++
 rtl/zeroriscy_instr_mem_responder.sv | 97 +++++++++
 tb/tb_zeroriscy_instr_mem_responder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zeroriscy_instr_mem_responder_pkg.sv
// zeroriscy_instr_mem_responder_pkg: shared types, constants and address helpers for the instruction memory responder.
package zeroriscy_instr_mem_responder_pkg;

    typedef enum logic {IR_IDLE, IR_STALL} instr_resp_state_e;

    // All-zero word decodes as an illegal instruction in the core.
    localparam logic [31:0] INSTR_OOR_DATA = 32'h0000_0000;

    function automatic logic [29:0] word_offset(logic [31:0] a, logic [31:0] base);
        return 30'((a - base) >> 2);
    endfunction

    function automatic logic word_in_range(logic [29:0] w, int unsigned depth);
        return {2'b00, w} < depth;
    endfunction

endpackage

// File: rtl/zeroriscy_instr_mem_responder_if.sv
// zeroriscy_instr_mem_responder_if: zero-riscy instruction fetch bus (master = core prefetch, slave = memory).
// Signals: req/addr from core; gnt, rvalid, rdata from memory.
interface zeroriscy_instr_mem_responder_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/zeroriscy_instr_resp_pipe.sv
// zeroriscy_instr_resp_pipe: fixed-latency valid+payload shift pipeline whose last stage captures a caller-supplied word.
// Ports: clk, rst_n (sync, active-low); in_valid/in_data enter stage 0; tap_data is the payload about to enter the
// final stage, last_data is what the final stage registers from it; out_valid/out_data are the final stage.
module zeroriscy_instr_resp_pipe #(
    parameter int STAGES = 1,
    parameter int W      = 8,
    parameter int LW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic [W-1:0]  tap_data,
    input  logic [LW-1:0] last_data,
    output logic          out_valid,
    output logic [LW-1:0] out_data
);
    logic tap_valid;

    if (STAGES > 1) begin : g_mid
        logic [STAGES-2:0] v;
        logic [W-1:0]      d [STAGES-1];
        always_ff @(posedge clk) begin
            v[0] <= rst_n && in_valid;
            d[0] <= in_data;
            for (int i = 1; i < STAGES - 1; i++) begin
                v[i] <= rst_n && v[i-1];
                d[i] <= d[i-1];
            end
        end
        assign tap_valid = v[STAGES-2];
        assign tap_data  = d[STAGES-2];
    end else begin : g_direct
        assign tap_valid = in_valid;
        assign tap_data  = in_data;
    end

    // Final stage holds its payload between responses so the read data stays stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= tap_valid;
            if (tap_valid) out_data <= last_data;
        end
    end
endmodule

// File: rtl/zeroriscy_instr_mem_responder.sv
// zeroriscy_instr_mem_responder: memory-side responder for zero-riscy instruction fetches with backdoor preload.
// Ports: clk, rst_n (sync, active-low); bus (slave fetch interface: req/addr in, gnt/rvalid/rdata out);
// load_we_i/load_addr_i/load_data_i backdoor word write; range_err_o flags out-of-range responses; busy_o
// is high while any granted request is unanswered.
module zeroriscy_instr_mem_responder
    import zeroriscy_instr_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          DEPTH_WORDS     = 1024,
    parameter int          GNT_STALL       = 0,
    parameter int          RESP_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    zeroriscy_instr_mem_responder_if.slave        bus,
    input  logic                                  load_we_i,
    input  logic [31:0]                           load_addr_i,
    input  logic [31:0]                           load_data_i,
    output logic                                  range_err_o,
    output logic                                  busy_o
);
    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int MAXE = MAX_OUTSTANDING < 1 ? 1 :
                          (MAX_OUTSTANDING > RESP_LATENCY + 1 ? RESP_LATENCY + 1 : MAX_OUTSTANDING);
    localparam int CW   = $clog2(MAXE) + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAXE);

    logic [31:0]       mem [DEPTH_WORDS];
    instr_resp_state_e state;
    logic [3:0]        scnt;
    logic [CW-1:0]     cnt;
    logic [29:0]       req_woff;
    logic [29:0]       load_woff;
    logic [AW:0]       req_ent;
    logic [AW:0]       tap;
    logic [32:0]       resp;
    logic [32:0]       out;
    logic              room;
    logic              hs;
    logic              rv;

    assign req_woff  = word_offset(bus.addr, BASE_ADDR);
    assign load_woff = word_offset(load_addr_i, BASE_ADDR);
    assign req_ent   = {word_in_range(req_woff, DEPTH_WORDS), req_woff[AW-1:0]};
    // A response leaving this cycle frees its slot for a grant in the same cycle.
    assign room      = cnt < MAX_C || rv;
    assign bus.gnt   = rst_n && bus.req && room && (GNT_STALL == 0 || (state == IR_STALL && scnt == 4'd0));
    assign hs        = bus.req && bus.gnt;
    assign busy_o    = rst_n && cnt != '0;
    // Memory is read as the final stage loads, so a same-edge backdoor write returns the old word.
    assign resp      = {~tap[AW], tap[AW] ? mem[tap[AW-1:0]] : INSTR_OOR_DATA};
    assign bus.rvalid = rv;
    assign bus.rdata  = out[31:0];
    assign range_err_o = rv && out[32];

    zeroriscy_instr_resp_pipe #(
        .STAGES (RESP_LATENCY),
        .W      (AW + 1),
        .LW     (33)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (hs),
        .in_data   (req_ent),
        .tap_data  (tap),
        .last_data (resp),
        .out_valid (rv),
        .out_data  (out)
    );

    // Each request pays its own stall; dropping req abandons the stall without a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IR_IDLE;
            scnt  <= 4'd0;
        end else if (state == IR_IDLE) begin
            if (bus.req && GNT_STALL != 0) begin
                state <= IR_STALL;
                scnt  <= 4'(GNT_STALL - 1);
            end
        end else if (!bus.req || hs) begin
            state <= IR_IDLE;
        end else if (scnt != 4'd0) begin
            scnt <= scnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else cnt <= cnt + CW'(hs) - CW'(rv);
    end

    always_ff @(posedge clk) begin
        if (load_we_i && word_in_range(load_woff, DEPTH_WORDS)) mem[load_woff[AW-1:0]] <= load_data_i;
    end
endmodule

// File: tb/tb_zeroriscy_instr_mem_responder.sv
// tb_zeroriscy_instr_mem_responder: scoreboard bench for three responder configurations sharing one backdoor load port.
module tb_zeroriscy_instr_mem_responder;
    typedef struct {
        int          k;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic [2:0]  req;
    logic [2:0]  rst_n;
    logic [31:0] addr [3];
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    wire  [2:0]  gnt;
    wire  [2:0]  rv;
    wire  [2:0]  rerr;
    wire  [2:0]  busy;
    wire  [31:0] rdata [3];

    logic [31:0] tb_mem [16];
    exp_t        q [$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          a4 [6] = '{8, 12, 16, 16, 20, 24};
    logic        g4 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int          a5 [4] = '{64, -4, 60, 0};

    zeroriscy_instr_mem_responder_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].req  = req[g];
        assign bus[g].addr = addr[g];
        assign gnt[g]      = bus[g].gnt;
        assign rv[g]       = bus[g].rvalid;
        assign rdata[g]    = bus[g].rdata;
        zeroriscy_instr_mem_responder #(
            .BASE_ADDR       (32'h0000_0000),
            .DEPTH_WORDS     (16),
            .GNT_STALL       (g == 1 ? 2 : 0),
            .RESP_LATENCY    (g == 2 ? 3 : 1),
            .MAX_OUTSTANDING (2)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n[g]),
            .bus         (bus[g]),
            .load_we_i   (load_we),
            .load_addr_i (load_addr),
            .load_data_i (load_data),
            .range_err_o (rerr[g]),
            .busy_o      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(int k);
        return k == 2 ? 3 : 1;
    endfunction

    function automatic exp_t expect_for(int k, logic [31:0] a);
        exp_t e;
        e.k    = k;
        e.err  = a >= 32'd64;
        e.data = e.err ? 32'h0 : tb_mem[a[5:2]];
        e.due  = cyc + lat(k);
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", n, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [31:0] a, logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_we = 1'b0;
    endtask

    // Monitor pops and compares every response, then records newly granted requests.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (gnt[k] && !(req[k] && rst_n[k])) begin
                tests++;
                fails++;
                $display("FAIL gnt_qual dut%0d: gnt=1 req=%b rst_n=%b, required gnt=0", k, req[k], rst_n[k]);
            end
            if (rv[k]) begin
                tests++;
                if (q.size() == 0 || q[0].k != k) begin
                    fails++;
                    $display("FAIL unexpected_rvalid dut%0d: rvalid=1 rdata=%h, required no response", k, rdata[k]);
                end else begin
                    e = q.pop_front();
                    if (rdata[k] !== e.data || rerr[k] !== e.err || cyc != e.due) begin
                        fails++;
                        $display("FAIL response dut%0d: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                                 k, rdata[k], rerr[k], cyc, e.data, e.err, e.due);
                    end
                end
            end else if (rerr[k]) begin
                tests++;
                fails++;
                $display("FAIL err_without_rvalid dut%0d: range_err=1, required 0", k);
            end
        end
        for (int k = 0; k < 3; k++) if (req[k] && gnt[k]) q.push_back(expect_for(k, addr[k]));
    end

    initial begin
        req       = 3'b001;
        rst_n     = 3'b000;
        load_we   = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
        for (int k = 0; k < 3; k++) addr[k] = 32'h0;
        @(negedge clk);
        chk("reset_gnt", {31'h0, gnt[0]}, 32'h0);
        chk("reset_busy", {29'h0, busy}, 32'h0);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            chk("reset_rvalid", {31'h0, rv[k]}, 32'h0);
            chk("reset_rdata", rdata[k], 32'h0);
            chk("reset_err", {31'h0, rerr[k]}, 32'h0);
        end
        req   = 3'b000;
        rst_n = 3'b111;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i] = i == 0 ? 32'h0000_0013 : 32'hA500_0000 | 32'(i * 32'h111);
            load(32'(4 * i), tb_mem[i]);
        end
        load(32'h0000_0040, 32'hDEAD_BEEF);
        load(32'hFFFF_FFFC, 32'hCAFE_F00D);

        req[0]  = 1'b1;
        addr[0] = 32'h0;
        @(negedge clk);
        chk("single_gnt_same_cycle", {31'h0, gnt[0]}, 32'h1);
        step();
        req[0] = 1'b0;
        repeat (3) step();

        req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr[0] = 32'(4 * i);
            @(negedge clk);
            chk("burst_gnt", {31'h0, gnt[0]}, 32'h1);
            step();
        end
        req[0] = 1'b0;
        repeat (3) step();

        req[1]  = 1'b1;
        addr[1] = 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_gnt", {31'h0, gnt[1]}, i == 2 ? 32'h1 : 32'h0);
            step();
        end
        req[1] = 1'b0;
        @(negedge clk);
        chk("stall_busy_in_flight", {31'h0, busy[1]}, 32'h1);
        step();
        @(negedge clk);
        chk("stall_busy_drained", {31'h0, busy[1]}, 32'h0);
        step();
        req[1]  = 1'b1;
        addr[1] = 32'h8;
        @(negedge clk);
        chk("abandon_gnt0", {31'h0, gnt[1]}, 32'h0);
        step();
        req[1] = 1'b0;
        @(negedge clk);
        chk("abandon_gnt1", {31'h0, gnt[1]}, 32'h0);
        step();
        req[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("restall_gnt", {31'h0, gnt[1]}, i == 2 ? 32'h1 : 32'h0);
            step();
        end
        req[1] = 1'b0;
        repeat (3) step();

        req[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            addr[2] = 32'(a4[i]);
            @(negedge clk);
            chk("limit_gnt", {31'h0, gnt[2]}, {31'h0, g4[i]});
            if (i == 2) chk("limit_busy", {31'h0, busy[2]}, 32'h1);
            step();
        end
        req[2] = 1'b0;
        repeat (6) step();

        req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr[0] = 32'(a5[i]);
            @(negedge clk);
            chk("range_gnt", {31'h0, gnt[0]}, 32'h1);
            step();
        end
        req[0] = 1'b0;
        repeat (3) step();

        req[0]    = 1'b1;
        addr[0]   = 32'd20;
        load_we   = 1'b1;
        load_addr = 32'd20;
        load_data = 32'h5555_AAAA;
        @(negedge clk);
        chk("collide_gnt", {31'h0, gnt[0]}, 32'h1);
        step();
        load_we    = 1'b0;
        tb_mem[5]  = 32'h5555_AAAA;
        @(negedge clk);
        chk("reread_gnt", {31'h0, gnt[0]}, 32'h1);
        step();
        req[0] = 1'b0;
        repeat (3) step();

        req[2]  = 1'b1;
        addr[2] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("flush_setup_gnt", {31'h0, gnt[2]}, 32'h1);
            step();
        end
        req[2]   = 1'b0;
        rst_n[2] = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_busy_in_reset", {31'h0, busy[2]}, 32'h0);
        step();
        rst_n[2] = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("flush_busy_after", {31'h0, busy[2]}, 32'h0);
        step();
        req[2]  = 1'b1;
        addr[2] = 32'h4;
        @(negedge clk);
        chk("post_reset_gnt", {31'h0, gnt[2]}, 32'h1);
        step();
        req[2] = 1'b0;
        repeat (6) step();

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
